// File: rtl/dht_sensor_emu.sv
// DHT11-compatible sensor emulator: detects a host start pulse on the open-drain
// line and answers with the response preamble plus a 40-bit humidity/temperature frame.
module dht_sensor_emu #(
  parameter int START_MIN_US = 18000,
  parameter int HOST_WAIT_US = 30,
  parameter int RESP_LOW_US  = 80,
  parameter int RESP_HIGH_US = 80,
  parameter int BIT_LOW_US   = 50,
  parameter int BIT0_HIGH_US = 26,
  parameter int BIT1_HIGH_US = 70
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1us,
  input  logic [7:0]  i_hum_int,
  input  logic [7:0]  i_hum_dec,
  input  logic [7:0]  i_tmp_int,
  input  logic [7:0]  i_tmp_dec,
  inout  wire         io_dht,
  output logic        o_busy,
  output logic        o_done,
  output logic [39:0] o_frame
);

  typedef enum logic [2:0] {
    IDLE, HOST_LOW, HOST_GAP, RESP_L, RESP_H, BIT_L, BIT_H, END_L
  } state_t;

  localparam logic [14:0] START_LAST = 15'(START_MIN_US - 1);
  localparam logic [14:0] WAIT_LAST  = 15'(HOST_WAIT_US - 1);
  localparam logic [14:0] RLOW_LAST  = 15'(RESP_LOW_US - 1);
  localparam logic [14:0] RHIGH_LAST = 15'(RESP_HIGH_US - 1);
  localparam logic [14:0] BLOW_LAST  = 15'(BIT_LOW_US - 1);
  localparam logic [14:0] B0_LAST    = 15'(BIT0_HIGH_US - 1);
  localparam logic [14:0] B1_LAST    = 15'(BIT1_HIGH_US - 1);

  function automatic logic [7:0] calc_chk(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

  state_t      state_q, state_d;
  logic [14:0] us_cnt_q, us_cnt_d;
  logic [5:0]  bit_idx_q, bit_idx_d;
  logic [39:0] frame_q, frame_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pull_low_q, pull_low_d;
  logic        dht_meta_q, dht_s_q;
  logic [39:0] shifted_s;
  logic [14:0] high_last_s;

  assign io_dht  = pull_low_q ? 1'b0 : 1'bz;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_frame = frame_q;

  // Next-state, phase counter and output computation.
  always_comb begin
    state_d     = state_q;
    us_cnt_d    = us_cnt_q;
    bit_idx_d   = bit_idx_q;
    frame_d     = frame_q;
    busy_d      = busy_q;
    shifted_s   = frame_q << bit_idx_q;
    high_last_s = shifted_s[39] ? B1_LAST : B0_LAST;
    // Drive follows the state by one clock; done lines up with the end-low release.
    pull_low_d  = (state_q == RESP_L) || (state_q == BIT_L) || (state_q == END_L);
    done_d      = (state_q == IDLE) && pull_low_q;
    if (done_d) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (tick_1us) begin
      us_cnt_d = us_cnt_q + 15'd1;
      case (state_q)
        IDLE: begin
          if (dht_s_q) begin
            us_cnt_d = 15'd0;
          end else if (us_cnt_q == START_LAST) begin
            state_d  = HOST_LOW;
            us_cnt_d = 15'd0;
            busy_d   = 1'b1;
          end else begin
            us_cnt_d = us_cnt_q + 15'd1;
          end
        end
        HOST_LOW: begin
          us_cnt_d = 15'd0;
          if (dht_s_q) begin
            state_d = HOST_GAP;
            frame_d = {i_hum_int, i_hum_dec, i_tmp_int, i_tmp_dec,
                       calc_chk(i_hum_int, i_hum_dec, i_tmp_int, i_tmp_dec)};
          end else begin
            state_d = HOST_LOW;
          end
        end
        HOST_GAP: if (us_cnt_q == WAIT_LAST)  begin state_d = RESP_L; us_cnt_d = 15'd0; end
                  else                        begin state_d = HOST_GAP; end
        RESP_L:   if (us_cnt_q == RLOW_LAST)  begin state_d = RESP_H; us_cnt_d = 15'd0; end
                  else                        begin state_d = RESP_L; end
        RESP_H:   if (us_cnt_q == RHIGH_LAST) begin state_d = BIT_L;  us_cnt_d = 15'd0; end
                  else                        begin state_d = RESP_H; end
        BIT_L:    if (us_cnt_q == BLOW_LAST)  begin state_d = BIT_H;  us_cnt_d = 15'd0; end
                  else                        begin state_d = BIT_L; end
        BIT_H: begin
          if (us_cnt_q == high_last_s) begin
            us_cnt_d = 15'd0;
            if (bit_idx_q == 6'd39) begin
              bit_idx_d = 6'd0;
              state_d   = END_L;
            end else begin
              bit_idx_d = bit_idx_q + 6'd1;
              state_d   = BIT_L;
            end
          end else begin
            state_d = BIT_H;
          end
        end
        END_L:    if (us_cnt_q == BLOW_LAST)  begin state_d = IDLE;   us_cnt_d = 15'd0; end
                  else                        begin state_d = END_L; end
        default: begin
          state_d  = IDLE;
          us_cnt_d = 15'd0;
        end
      endcase
    end else begin
      us_cnt_d = us_cnt_q;
    end
  end

  // State, synchronizer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      us_cnt_q   <= 15'd0;
      bit_idx_q  <= 6'd0;
      frame_q    <= 40'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pull_low_q <= 1'b0;
      dht_meta_q <= 1'b1;
      dht_s_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      us_cnt_q   <= us_cnt_d;
      bit_idx_q  <= bit_idx_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pull_low_q <= pull_low_d;
      dht_meta_q <= io_dht;
      dht_s_q    <= dht_meta_q;
    end
  end

endmodule
